// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one FP16 multiplier among NREQ requesters.
// Each operation runs IDLE -> ISSUE -> BUSY -> RESP -> CLEAR, with a watchdog in BUSY.
module fpu_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int FLAGW   = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         reqValid,
    input  logic [NREQ*16-1:0]      reqIn1,
    input  logic [NREQ*16-1:0]      reqIn2,
    output logic [NREQ-1:0]         reqReady,
    output logic [NREQ-1:0]         respValid,
    input  logic [NREQ-1:0]         respReady,
    output logic [15:0]             respOut,
    output logic [3:0]              respCond,
    output logic [FLAGW-1:0]        respFlags,
    output logic                    respTimeout,
    output logic [15:0]             unitIn1,
    output logic [15:0]             unitIn2,
    output logic                    unitStart,
    output logic                    unitClear,
    input  logic                    unitDone,
    input  logic [15:0]             unitOut,
    input  logic [3:0]              unitCond,
    input  logic [FLAGW-1:0]        unitFlags,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int IDXW = $clog2(NREQ);
    localparam int CNTW = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] LASTCOUNT = CNTW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, CLEAR} ArbState;

    ArbState state, nextState;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] grantIdx;
    logic [IDXW-1:0] cand;
    logic            grantFound;
    int              candSum;
    logic [CNTW-1:0] count;
    logic [15:0]     opA, opB;

    // Search upward from the requester after the last winner, wrapping once.
    always_comb begin
        grantIdx   = '0;
        grantFound = 1'b0;
        cand       = '0;
        candSum    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            candSum = int'(ptr) + k;
            if (candSum >= NREQ) candSum = candSum - NREQ;
            cand = IDXW'(candSum);
            if (!grantFound && reqValid[cand]) begin
                grantFound = 1'b1;
                grantIdx   = cand;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Grants are only visible while idle and out of reset.
    always_comb begin
        nextState = state;
        reqReady  = '0;
        respValid = '0;
        unitStart = 1'b0;
        unitClear = 1'b0;
        case (state)
            IDLE: begin
                if (grantFound && !reset) begin
                    reqReady[grantIdx] = 1'b1;
                    nextState          = ISSUE;
                end
            end
            ISSUE: begin
                unitStart = 1'b1;
                nextState = BUSY;
            end
            BUSY: begin
                if (unitDone || count == LASTCOUNT) nextState = RESP;
            end
            RESP: begin
                respValid[owner] = 1'b1;
                if (respReady[owner]) nextState = CLEAR;
            end
            CLEAR: begin
                unitClear = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Operand capture, watchdog counting and response capture; a real result beats the watchdog.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr         <= IDXW'(NREQ - 1);
            owner       <= '0;
            count       <= '0;
            opA         <= '0;
            opB         <= '0;
            respOut     <= '0;
            respCond    <= '0;
            respFlags   <= '0;
            respTimeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantFound) begin
                        opA   <= reqIn1[{grantIdx, 4'b0000} +: 16];
                        opB   <= reqIn2[{grantIdx, 4'b0000} +: 16];
                        owner <= grantIdx;
                        ptr   <= grantIdx;
                    end
                end
                ISSUE: count <= '0;
                BUSY: begin
                    count <= count + CNTW'(1);
                    if (unitDone) begin
                        respOut     <= unitOut;
                        respCond    <= unitCond;
                        respFlags   <= unitFlags;
                        respTimeout <= 1'b0;
                    end else if (count == LASTCOUNT) begin
                        respOut     <= 16'h7E00;
                        respCond    <= '0;
                        respFlags   <= '0;
                        respTimeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign unitIn1 = (state == ISSUE || state == BUSY) ? opA : 16'h0000;
    assign unitIn2 = (state == ISSUE || state == BUSY) ? opB : 16'h0000;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter: basic multiply, round-robin order, watchdog,
// done/timeout tie, stalled response and mid-operation reset.
module tb_fpu_mul_arbiter;

    localparam int NREQ  = 4;
    localparam int FLAGW = 5;

    logic              clock;
    logic              reset;
    logic [NREQ-1:0]   reqValid;
    logic [NREQ*16-1:0] reqIn1;
    logic [NREQ*16-1:0] reqIn2;
    logic [NREQ-1:0]   reqReady;
    logic [NREQ-1:0]   respValid;
    logic [NREQ-1:0]   respReady;
    logic [15:0]       respOut;
    logic [3:0]        respCond;
    logic [FLAGW-1:0]  respFlags;
    logic              respTimeout;
    logic [15:0]       unitIn1;
    logic [15:0]       unitIn2;
    logic              unitStart;
    logic              unitClear;
    logic              unitDone;
    logic [15:0]       unitOut;
    logic [3:0]        unitCond;
    logic [FLAGW-1:0]  unitFlags;
    logic              busy;
    logic [1:0]        owner;

    int total = 0;
    int bad   = 0;

    fpu_mul_arbiter #(.NREQ(NREQ), .TIMEOUT(64), .FLAGW(FLAGW)) dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqIn1(reqIn1), .reqIn2(reqIn2), .reqReady(reqReady),
        .respValid(respValid), .respReady(respReady),
        .respOut(respOut), .respCond(respCond), .respFlags(respFlags), .respTimeout(respTimeout),
        .unitIn1(unitIn1), .unitIn2(unitIn2), .unitStart(unitStart), .unitClear(unitClear),
        .unitDone(unitDone), .unitOut(unitOut), .unitCond(unitCond), .unitFlags(unitFlags),
        .busy(busy), .owner(owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=hang expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] rv, input logic [NREQ-1:0] rr, input logic done);
        reqValid  = rv;
        respReady = rr;
        unitDone  = done;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One complete operation for the expected winner with the unit finishing on the first BUSY cycle.
    task automatic serve(input int expIdx, input string tag);
        logic [3:0] oneHot;
        oneHot = 4'(1 << expIdx);
        checkOutput({tag, "_rdy"}, 32'(reqReady), 32'(oneHot));
        checkOutput({tag, "_idlebusy"}, 32'(busy), 32'd0);
        tick();
        checkOutput({tag, "_start"}, 32'(unitStart), 32'd1);
        checkOutput({tag, "_owner"}, 32'(owner), 32'(expIdx));
        checkOutput({tag, "_rdyoff"}, 32'(reqReady), 32'd0);
        tick();
        unitOut   = 16'h4000 + 16'(expIdx);
        unitCond  = 4'b0000;
        unitFlags = '0;
        applyStimulus(reqValid, 4'b0000, 1'b1);
        tick();
        checkOutput({tag, "_rv"}, 32'(respValid), 32'(oneHot));
        checkOutput({tag, "_out"}, 32'(respOut), 32'h4000 + 32'(expIdx));
        applyStimulus(reqValid, oneHot, 1'b1);
        tick();
        checkOutput({tag, "_clr"}, 32'(unitClear), 32'd1);
        checkOutput({tag, "_clrrdy"}, 32'(reqReady), 32'd0);
        applyStimulus(reqValid, 4'b0000, 1'b0);
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        reqValid  = '0;
        respReady = '0;
        unitDone  = 1'b0;
        unitOut   = '0;
        unitCond  = '0;
        unitFlags = '0;
        for (int i = 0; i < NREQ; i++) begin
            reqIn1[16*i +: 16] = 16'h1000 + 16'(i);
            reqIn2[16*i +: 16] = 16'h2000 + 16'(i);
        end
        reqIn1[15:0] = 16'h3E00;
        reqIn2[15:0] = 16'h4000;

        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        checkOutput("rst_resp", 32'(respOut), 32'd0);
        checkOutput("rst_rv", 32'(respValid), 32'd0);
        checkOutput("rst_in1", 32'(unitIn1), 32'd0);
        reset = 1'b0;
        tick();

        // Single multiply 1.5*2.0, unit done on cycle 5.
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        checkOutput("v1_rdy", 32'(reqReady), 32'h1);
        checkOutput("v1_in1idle", 32'(unitIn1), 32'd0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("v1_start", 32'(unitStart), 32'd1);
        checkOutput("v1_busy", 32'(busy), 32'd1);
        checkOutput("v1_in1", 32'(unitIn1), 32'h3E00);
        checkOutput("v1_in2", 32'(unitIn2), 32'h4000);
        tick();
        checkOutput("v1_startoff", 32'(unitStart), 32'd0);
        checkOutput("v1_in1hold", 32'(unitIn1), 32'h3E00);
        tick();
        tick();
        tick();
        unitOut   = 16'h4200;
        unitCond  = 4'b0010;
        unitFlags = 5'b00001;
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("v1_rvearly", 32'(respValid), 32'd0);
        tick();
        checkOutput("v1_rv", 32'(respValid), 32'h1);
        checkOutput("v1_out", 32'(respOut), 32'h4200);
        checkOutput("v1_cond", 32'(respCond), 32'h2);
        checkOutput("v1_flags", 32'(respFlags), 32'h1);
        checkOutput("v1_tmo", 32'(respTimeout), 32'd0);
        applyStimulus(4'b0000, 4'b0001, 1'b1);
        tick();
        checkOutput("v1_clr", 32'(unitClear), 32'd1);
        checkOutput("v1_rvoff", 32'(respValid), 32'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("v1_clroff", 32'(unitClear), 32'd0);
        checkOutput("v1_idle", 32'(busy), 32'd0);

        // Stalled response: req1 wins, its result is held while everyone else clamours.
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        checkOutput("v5_rdy", 32'(reqReady), 32'h2);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        unitOut   = 16'h5A5A;
        unitCond  = 4'b1001;
        unitFlags = 5'b10100;
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        tick();
        applyStimulus(4'b1111, 4'b1101, 1'b1);
        for (int i = 0; i < 10; i++) begin
            unitOut  = 16'hDEAD + 16'(i);
            unitCond = 4'(i);
            #1;
            checkOutput("v5_rv", 32'(respValid), 32'h2);
            checkOutput("v5_out", 32'(respOut), 32'h5A5A);
            checkOutput("v5_cond", 32'(respCond), 32'h9);
            checkOutput("v5_flags", 32'(respFlags), 32'h14);
            checkOutput("v5_rdy0", 32'(reqReady), 32'd0);
            checkOutput("v5_clr0", 32'(unitClear), 32'd0);
            tick();
        end
        applyStimulus(4'b1111, 4'b0010, 1'b1);
        tick();
        checkOutput("v5_clr", 32'(unitClear), 32'd1);
        checkOutput("v5_clrrdy", 32'(reqReady), 32'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("v5_idle", 32'(busy), 32'd0);

        // Round robin from a fresh reset with everyone requesting.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        serve(0, "v2_g0");
        serve(1, "v2_g1");
        serve(2, "v2_g2");
        serve(3, "v2_g3");
        serve(0, "v2_g4");

        // Watchdog: req1 wins, the unit never finishes.
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        checkOutput("v3_rdy", 32'(reqReady), 32'h2);
        tick();
        unitOut   = 16'h1234;
        unitCond  = 4'hF;
        unitFlags = 5'h1F;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        for (int i = 0; i < 63; i++) tick();
        checkOutput("v3_rvearly", 32'(respValid), 32'd0);
        checkOutput("v3_busy", 32'(busy), 32'd1);
        checkOutput("v3_in1", 32'(unitIn1), 32'h1001);
        tick();
        checkOutput("v3_rv", 32'(respValid), 32'h2);
        checkOutput("v3_out", 32'(respOut), 32'h7E00);
        checkOutput("v3_tmo", 32'(respTimeout), 32'd1);
        checkOutput("v3_cond", 32'(respCond), 32'd0);
        checkOutput("v3_flags", 32'(respFlags), 32'd0);
        applyStimulus(4'b0000, 4'b0010, 1'b0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();

        // Done arrives on the very cycle the watchdog expires.
        applyStimulus(4'b0100, 4'b0000, 1'b0);
        checkOutput("v4_rdy", 32'(reqReady), 32'h4);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        for (int i = 0; i < 62; i++) tick();
        tick();
        unitOut   = 16'h3C00;
        unitCond  = 4'b0100;
        unitFlags = 5'b00010;
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("v4_rvearly", 32'(respValid), 32'd0);
        tick();
        checkOutput("v4_rv", 32'(respValid), 32'h4);
        checkOutput("v4_out", 32'(respOut), 32'h3C00);
        checkOutput("v4_tmo", 32'(respTimeout), 32'd0);
        checkOutput("v4_cond", 32'(respCond), 32'h4);
        applyStimulus(4'b0000, 4'b0100, 1'b1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();

        // Reset in the middle of BUSY for req3, then req0 before req1.
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        checkOutput("v6_rdy", 32'(reqReady), 32'h8);
        tick();
        applyStimulus(4'b0011, 4'b0000, 1'b0);
        checkOutput("v6_owner", 32'(owner), 32'd3);
        tick();
        tick();
        reset = 1'b1;
        #1;
        checkOutput("v6_busy", 32'(busy), 32'd0);
        checkOutput("v6_owner0", 32'(owner), 32'd0);
        checkOutput("v6_rdy0", 32'(reqReady), 32'd0);
        checkOutput("v6_in1", 32'(unitIn1), 32'd0);
        checkOutput("v6_cond", 32'(respCond), 32'd0);
        checkOutput("v6_out", 32'(respOut), 32'd0);
        checkOutput("v6_rv", 32'(respValid), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        serve(0, "v6_g0");
        applyStimulus(4'b0011, 4'b0000, 1'b0);
        serve(1, "v6_g1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
